// File: rtl/aes_iter_core_if.sv
// Handshake bundle for the iterative AES core: block/key offer on one side,
// ciphertext delivery on the other, plus a busy indicator.
interface aes_iter_core_if #(
  parameter int KEY_BITS = 128
);
  logic                in_valid;
  logic                in_ready;
  logic [127:0]        data_in;
  logic [KEY_BITS-1:0] key_in;
  logic                out_valid;
  logic                out_ready;
  logic [127:0]        data_out;
  logic                busy;

  // Block source / ciphertext sink side.
  modport master (
    output in_valid, data_in, key_in, out_ready,
    input  in_ready, out_valid, data_out, busy
  );

  // Engine side.
  modport slave (
    input  in_valid, data_in, key_in, out_ready,
    output in_ready, out_valid, data_out, busy
  );
endinterface

// File: rtl/aes_iter_core.sv
// Iterative AES-128/256 encryption engine. One round per clock through a
// shared round datapath; round keys are expanded on the fly from a key
// window register, with Rcon kept as its own register advanced by xtime.
module aes_iter_core #(
  parameter int KEY_BITS = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  aes_iter_core_if.slave       bus
);

  if (!(KEY_BITS == 128 || KEY_BITS == 256)) begin : g_bad_key_bits
    $error("aes_iter_core: KEY_BITS must be 128 or 256");
  end

  localparam logic [3:0] NR = (KEY_BITS == 256) ? 4'd14 : 4'd10;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry b sits (255-b) bytes up from the LSB end of the table.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // SubBytes, ShiftRows, optional MixColumns, AddRoundKey. Byte i is row i%4,
  // column i/4, stored at bits [127-8i -: 8].
  function automatic logic [127:0] aes_round(input logic [127:0] s,
                                             input logic [127:0] rk,
                                             input logic         fin);
    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] m;
    m = '0;
    for (int i = 0; i < 16; i++) sb[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[4*c+r] = sb[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c]; a1 = sr[4*c+1]; a2 = sr[4*c+2]; a3 = sr[4*c+3];
      if (fin)
        m[127-32*c -: 32] = {a0, a1, a2, a3};
      else
        m[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                             a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                             a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                             xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return m ^ rk;
  endfunction

  // One 4-word expansion step: prev holds w[i-Nk..i-Nk+3], last is w[i-1].
  // rot selects RotWord+SubWord+Rcon; otherwise SubWord only.
  function automatic logic [127:0] kexp(input logic [127:0] prev,
                                        input logic [31:0]  last,
                                        input logic         rot,
                                        input logic [7:0]   rc);
    logic [31:0] t, w0, w1, w2, w3;
    if (rot)
      t = {sbox(last[23:16]) ^ rc, sbox(last[15:8]), sbox(last[7:0]), sbox(last[31:24])};
    else
      t = {sbox(last[31:24]), sbox(last[23:16]), sbox(last[15:8]), sbox(last[7:0])};
    w0 = prev[127:96] ^ t;
    w1 = prev[95:64]  ^ w0;
    w2 = prev[63:32]  ^ w1;
    w3 = prev[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e              state_q, state_d;
  logic [127:0]        st_q, st_d;
  logic [KEY_BITS-1:0] key_q, key_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [7:0]          rcon_q, rcon_d;
  logic [127:0]        dout_q, dout_d;

  logic [127:0]        rk_cur;
  logic [KEY_BITS-1:0] key_nxt;
  logic [7:0]          rcon_nxt;
  logic [127:0]        rnd;

  if (KEY_BITS == 128) begin : g_k128
    // key_q holds rk[cnt-1]; this round's key is expanded from it.
    assign rk_cur   = kexp(key_q, key_q[31:0], 1'b1, rcon_q);
    assign key_nxt  = rk_cur;
    assign rcon_nxt = xt(rcon_q);
  end else begin : g_k256
    // key_q holds {rk[cnt-1], rk[cnt]}; rk[cnt+1] is prepared for next edge.
    // rk[cnt+1] is an even step (Rot+Sub+Rcon) exactly when cnt is odd.
    logic [127:0] rk_new;
    assign rk_cur   = key_q[127:0];
    assign rk_new   = kexp(key_q[KEY_BITS-1 -: 128], key_q[31:0], cnt_q[0], rcon_q);
    assign key_nxt  = {key_q[127:0], rk_new};
    assign rcon_nxt = cnt_q[0] ? xt(rcon_q) : rcon_q;
  end

  assign rnd = aes_round(st_q, rk_cur, cnt_q == NR);

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q == RUN);
  assign bus.out_valid = (state_q == DONE);
  assign bus.data_out  = dout_q;

  // State and datapath registers; reset discards any block in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      st_q    <= '0;
      key_q   <= '0;
      cnt_q   <= '0;
      rcon_q  <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      rcon_q  <= rcon_d;
      dout_q  <= dout_d;
    end
  end

  // Next-state: capture on accept, one round per edge in RUN, hold in DONE.
  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    rcon_d  = rcon_q;
    dout_d  = dout_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          st_d    = bus.data_in ^ bus.key_in[KEY_BITS-1 -: 128];
          key_d   = bus.key_in;
          cnt_d   = 4'd1;
          rcon_d  = 8'h01;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == NR) begin
          dout_d  = rnd;
          cnt_d   = 4'd0;
          state_d = DONE;
        end else begin
          st_d   = rnd;
          key_d  = key_nxt;
          rcon_d = rcon_nxt;
          cnt_d  = cnt_q + 4'd1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes_iter_core.sv
// Directed FIPS-197 vectors against AES-128 and AES-256 instances.
module tb_aes_iter_core;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] K2 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C2 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] K3 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P3 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C3 = 128'h3925841d02dc09fbdc118597196a0b32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  aes_iter_core_if #(.KEY_BITS(128)) b128 ();
  aes_iter_core_if #(.KEY_BITS(256)) b256 ();

  aes_iter_core #(.KEY_BITS(128)) u128 (.clk(clk), .rst(rst), .bus(b128));
  aes_iter_core #(.KEY_BITS(256)) u256 (.clk(clk), .rst(rst), .bus(b256));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  // Offer one block to the 128-bit core, wait for ciphertext, check latency and data.
  task automatic do128(input string tag, input logic [127:0] key, input logic [127:0] pt,
                       input logic [127:0] ct, input bit scramble);
    int n;
    b128.data_in = pt; b128.key_in = key; b128.in_valid = 1'b1;
    n = 0;
    while (!b128.in_ready && n < 40) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    b128.in_valid = 1'b0;
    n = 0;
    while (!b128.out_valid && n < 40) begin
      if (scramble) begin
        b128.data_in = {$urandom, $urandom, $urandom, $urandom};
        b128.key_in  = {$urandom, $urandom, $urandom, $urandom};
      end
      @(posedge clk); #1; n++;
    end
    chk({tag, "_lat"}, 128'(n), 128'd10);
    chk({tag, "_ct"}, b128.data_out, ct);
  endtask

  task automatic do256(input string tag, input logic [255:0] key, input logic [127:0] pt,
                       input logic [127:0] ct);
    int n;
    b256.data_in = pt; b256.key_in = key; b256.in_valid = 1'b1;
    n = 0;
    while (!b256.in_ready && n < 40) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    b256.in_valid = 1'b0;
    n = 0;
    while (!b256.out_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk({tag, "_lat"}, 128'(n), 128'd14);
    chk({tag, "_ct"}, b256.data_out, ct);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int           cyc, nacc, nout, acc_t [2];
    logic         acc, ov, seen;
    logic [127:0] dq, outs [2];

    b128.in_valid = 0; b128.data_in = '0; b128.key_in = '0; b128.out_ready = 1;
    b256.in_valid = 0; b256.data_in = '0; b256.key_in = '0; b256.out_ready = 1;

    // Reset state
    #12;
    chk("rst_in_ready", 128'(b128.in_ready), 128'd1);
    chk("rst_out_valid", 128'(b128.out_valid), 128'd0);
    chk("rst_busy", 128'(b128.busy), 128'd0);
    chk("rst_dout", b128.data_out, 128'd0);
    chk("rst_dout256", b256.data_out, 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: AES-128 FIPS-197 C.1
    do128("v1", K1, P1, C1, 1'b0);
    @(posedge clk); #1;
    chk("v1_release_ov", 128'(b128.out_valid), 128'd0);
    chk("v1_release_rdy", 128'(b128.in_ready), 128'd1);

    // 2: AES-256 FIPS-197 C.3
    do256("v2", K2, P1, C2);

    // 3: backpressure, held output, ignored second offer
    b128.out_ready = 1'b0;
    do128("v3", K3, P3, C3, 1'b0);
    for (int i = 0; i < 20; i++) begin
      b128.in_valid = 1'b1; b128.data_in = P1; b128.key_in = K1;
      @(posedge clk); #1;
      chk("v3_hold_ov", 128'(b128.out_valid), 128'd1);
      chk("v3_hold_ct", b128.data_out, C3);
      chk("v3_hold_rdy", 128'(b128.in_ready), 128'd0);
    end
    b128.in_valid = 1'b0;
    b128.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("v3_drain_ov", 128'(b128.out_valid), 128'd0);
    chk("v3_drain_busy", 128'(b128.busy), 128'd0);
    chk("v3_drain_rdy", 128'(b128.in_ready), 128'd1);

    // 4: back-to-back with in_valid held high
    b128.data_in = P1; b128.key_in = K1; b128.in_valid = 1'b1;
    cyc = 0; nacc = 0; nout = 0;
    acc_t[0] = 0; acc_t[1] = 0; outs[0] = '0; outs[1] = '0;
    while (nout < 2 && cyc < 100) begin
      acc = b128.in_valid && b128.in_ready;
      ov  = b128.out_valid;
      dq  = b128.data_out;
      @(posedge clk); #1; cyc++;
      if (acc) begin
        if (nacc < 2) acc_t[nacc] = cyc;
        nacc++;
        if (nacc == 1) begin b128.data_in = P3; b128.key_in = K3; end
        else b128.in_valid = 1'b0;
      end
      if (ov) begin
        if (nout < 2) outs[nout] = dq;
        nout++;
      end
    end
    b128.in_valid = 1'b0;
    chk("b2b_nout", 128'(nout), 128'd2);
    chk("b2b_ct0", outs[0], C1);
    chk("b2b_ct1", outs[1], C3);
    chk("b2b_gap", 128'(acc_t[1] - acc_t[0]), 128'd12);

    // 5: reset mid-run discards the block
    @(posedge clk); #1;
    b128.data_in = P1; b128.key_in = K1; b128.in_valid = 1'b1;
    @(posedge clk); #1;
    b128.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort_dout", b128.data_out, 128'd0);
    chk("abort_busy", 128'(b128.busy), 128'd0);
    chk("abort_rdy", 128'(b128.in_ready), 128'd1);
    chk("abort_ov", 128'(b128.out_valid), 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (b128.out_valid) seen = 1'b1;
    end
    chk("abort_no_ov", 128'(seen), 128'd0);
    do128("after_abort", K2[255:128], P1, C1, 1'b0);
    @(posedge clk); #1;

    // 6: inputs changing during RUN do not disturb the block
    do128("scr", K1, P1, C1, 1'b1);
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
